// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-end: button synchronise/debounce, IDLE/RUN/PAUSE control and 1 Hz tick
// prescaler. Every output is a register.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV        = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_start_stop,
  input  logic btn_mode,
  input  logic btn_plus2,
  input  logic btn_clear,
  input  logic count_zero,
  output logic start,
  output logic ups,
  output logic plus_min2,
  output logic force_reset,
  output logic running,
  output logic done
);

  localparam int unsigned PW     = $clog2(TICK_DIV);
  localparam int unsigned CW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned NumBtn = 4;
  localparam int unsigned BtnClear = 0;
  localparam int unsigned BtnStart = 1;
  localparam int unsigned BtnPlus  = 2;
  localparam int unsigned BtnMode  = 3;

  localparam logic [PW-1:0] PresLast = PW'(TICK_DIV - 1);
  // Counter holds samples-seen-minus-one; the accepting sample is the DEBOUNCE_CYCLES-th.
  localparam logic [CW-1:0] DbLast   = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  // ---------------------------------------------------------------------------
  // Button path
  // ---------------------------------------------------------------------------
  logic [NumBtn-1:0]         btn_raw;
  logic [NumBtn-1:0]         sync1_q, sync2_q;
  logic [NumBtn-1:0]         level_q, level_d, level_prev_q;
  logic [NumBtn-1:0]         press_q, press_d;
  logic [NumBtn-1:0][CW-1:0] cnt_q, cnt_d;

  always_comb begin
    btn_raw           = '0;
    btn_raw[BtnClear] = btn_clear;
    btn_raw[BtnStart] = btn_start_stop;
    btn_raw[BtnPlus]  = btn_plus2;
    btn_raw[BtnMode]  = btn_mode;
  end

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    for (int i = 0; i < NumBtn; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == DbLast) begin
          level_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    press_d = level_q & ~level_prev_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      press_q      <= '0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      press_q      <= press_d;
      cnt_q        <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Command decode: clear > start_stop > plus2 > mode
  // ---------------------------------------------------------------------------
  logic cmd_clear, cmd_start, cmd_plus, cmd_mode;

  always_comb begin
    cmd_clear = press_q[BtnClear];
    cmd_start = press_q[BtnStart] & ~press_q[BtnClear];
    cmd_plus  = press_q[BtnPlus] & ~press_q[BtnStart] & ~press_q[BtnClear];
    cmd_mode  = press_q[BtnMode] & ~press_q[BtnPlus] & ~press_q[BtnStart] &
                ~press_q[BtnClear];
  end

  // ---------------------------------------------------------------------------
  // Control FSM and prescaler
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_cyc, zero_hit;
  logic          start_d, ups_d, plus_min2_d, force_reset_d, running_d, done_d;

  always_comb begin
    tick_cyc = (state_q == StRun) && (presc_q == PresLast);
    zero_hit = tick_cyc && !ups && count_zero;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      presc_q     <= '0;
      start       <= 1'b0;
      ups         <= 1'b1;
      plus_min2   <= 1'b0;
      force_reset <= 1'b0;
      running     <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      start       <= start_d;
      ups         <= ups_d;
      plus_min2   <= plus_min2_d;
      force_reset <= force_reset_d;
      running     <= running_d;
      done        <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cmd_clear) begin
      state_d = StIdle;
    end else if (zero_hit) begin
      state_d = StPause;
    end else if (cmd_start) begin
      case (state_q)
        StIdle:  state_d = StRun;
        StRun:   state_d = StPause;
        StPause: state_d = StRun;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    // The tick cycle still counts as RUN time, so the prescaler wraps even when the
    // tick itself is suppressed by a down-count reaching zero.
    start_d       = tick_cyc && !zero_hit && !cmd_clear;
    done_d        = zero_hit && !cmd_clear;
    force_reset_d = cmd_clear;
    plus_min2_d   = cmd_plus && (state_q != StRun);
    ups_d         = ups ^ (cmd_mode && (state_q == StIdle));
    running_d     = (state_d == StRun);
    presc_d       = presc_q;
    if (cmd_clear || (state_q == StIdle)) begin
      presc_d = '0;
    end else if (state_q == StRun) begin
      presc_d = (presc_q == PresLast) ? '0 : presc_q + 1'b1;
    end
  end

  a_start_plus_exclusive : assert property (@(posedge clk) disable iff (!reset)
    !(start && plus_min2));
  a_running_matches_state : assert property (@(posedge clk) disable iff (!reset)
    running == (state_q == StRun));

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized bench for stopwatch_ctrl: a run-time based reference model predicts output
// pulses into a scoreboard queue that a negedge monitor drains and compares.
module tb_stopwatch_ctrl;

  localparam int unsigned TD  = 4;
  localparam int unsigned DB  = 3;
  localparam int          Lat = int'(DB) + 4;

  logic clk = 1'b0;
  logic reset;
  logic btn_start_stop, btn_mode, btn_plus2, btn_clear, count_zero;
  logic start, ups, plus_min2, force_reset, running, done;

  stopwatch_ctrl #(
    .TICK_DIV        (TD),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .btn_start_stop (btn_start_stop),
    .btn_mode       (btn_mode),
    .btn_plus2      (btn_plus2),
    .btn_clear      (btn_clear),
    .count_zero     (count_zero),
    .start          (start),
    .ups            (ups),
    .plus_min2      (plus_min2),
    .force_reset    (force_reset),
    .running        (running),
    .done           (done)
  );

  always #5 clk = ~clk;

  // Event kind bits: [3] start, [2] plus_min2, [1] force_reset, [0] done
  typedef struct {
    int         cyc;
    logic [3:0] kind;
  } ev_t;

  typedef enum {MIdle, MRun, MPause} mstate_e;

  ev_t        exp_q[$];
  logic [3:0] cmd_at[int];   // command bits {mode, plus2, start_stop, clear} by landing cycle
  int         cyc    = 0;
  int         phase  = 0;    // 1: reset values expected, 2: scoreboard active
  int         n_chk  = 0;
  int         n_fail = 0;

  mstate_e m_state   = MIdle;
  int      m_run     = 0;    // RUN cycles accumulated since last clear
  logic    m_ups     = 1'b1;
  logic    m_running = 1'b0;

  // ---------------------------------------------------------------------------
  // Reference model: one step per clock edge
  // ---------------------------------------------------------------------------
  task automatic model_step();
    logic [3:0] cmd;
    logic [3:0] ev;
    logic       tick;
    mstate_e    prev;
    cyc  = cyc + 1;
    prev = m_state;
    cmd  = cmd_at.exists(cyc) ? cmd_at[cyc] : 4'b0000;
    ev   = 4'b0000;
    tick = 1'b0;
    if (prev == MRun) begin
      m_run = m_run + 1;
      tick  = ((m_run % TD) == 0);
    end
    if (cmd[0]) begin
      m_state = MIdle;
      m_run   = 0;
      ev[1]   = 1'b1;
    end else if (tick && !m_ups && count_zero) begin
      ev[0]   = 1'b1;
      m_state = MPause;
    end else begin
      ev[3] = tick;
      if (cmd[1])                       m_state = (prev == MRun) ? MPause : MRun;
      else if (cmd[2])                  ev[2]   = (prev != MRun);
      else if (cmd[3] && prev == MIdle) m_ups   = !m_ups;
    end
    m_running = (m_state == MRun);
    if (ev != 4'b0000) exp_q.push_back('{cyc, ev});
  endtask

  initial forever begin
    @(posedge clk);
    if (phase == 2) model_step();
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, got, exp);
    end
  endtask

  logic [3:0] got;

  initial forever begin
    @(negedge clk);
    if (phase == 1) begin
      chk("reset_start",       {3'b000, start},       4'd0);
      chk("reset_ups",         {3'b000, ups},         4'd1);
      chk("reset_plus_min2",   {3'b000, plus_min2},   4'd0);
      chk("reset_force_reset", {3'b000, force_reset}, 4'd0);
      chk("reset_running",     {3'b000, running},     4'd0);
      chk("reset_done",        {3'b000, done},        4'd0);
    end else if (phase == 2) begin
      got = {start, plus_min2, force_reset, done};
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_chk  = n_chk + 1;
        n_fail = n_fail + 1;
        $display("FAIL missed_event at cycle %0d: got 0000, expected %b",
                 exp_q[0].cyc, exp_q[0].kind);
        void'(exp_q.pop_front());
      end
      if (got != 4'b0000) begin
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          n_chk  = n_chk + 1;
          n_fail = n_fail + 1;
          $display("FAIL unexpected_event at cycle %0d: got %b, expected 0000", cyc, got);
        end else begin
          chk("event_kind", got, exp_q[0].kind);
          void'(exp_q.pop_front());
        end
      end
      chk("running", {3'b000, running}, {3'b000, m_running});
      chk("ups",     {3'b000, ups},     {3'b000, m_ups});
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
    count_zero = ($urandom_range(0, 3) == 0);
  endtask

  task automatic set_btn(input logic [3:0] b);
    {btn_mode, btn_plus2, btn_start_stop, btn_clear} = b;
  endtask

  // Optional sub-debounce bounce bursts, then a clean hold long enough to be accepted.
  task automatic press(input logic [3:0] b, input int bounces, input int hold, input int gap);
    for (int k = 0; k < bounces; k++) begin
      set_btn(b);
      step();
      step();
      set_btn(4'b0000);
      step();
      step();
    end
    set_btn(b);
    if (cmd_at.exists(cyc + Lat)) cmd_at[cyc + Lat] = cmd_at[cyc + Lat] | b;
    else                          cmd_at[cyc + Lat] = b;
    repeat (hold) step();
    set_btn(4'b0000);
    repeat (gap) step();
  endtask

  localparam int Hold = int'(DB) + 2;
  localparam int Gap  = int'(DB) + 8;

  initial begin
    int         r;
    logic [3:0] b;
    reset      = 1'b0;
    count_zero = 1'b0;
    set_btn(4'b0000);
    phase = 1;
    repeat (3) step();
    reset = 1'b1;
    phase = 2;
    repeat (100) step();

    press(4'b0010, 5, Hold, 10);     // bouncy start_stop -> RUN
    press(4'b1000, 0, Hold, Gap);    // mode in RUN: ignored
    press(4'b0100, 0, Hold, Gap);    // plus2 in RUN: ignored
    press(4'b0010, 0, Hold, 20);     // pause
    press(4'b0100, 0, Hold, Gap);    // plus2 in PAUSE
    press(4'b1000, 0, Hold, Gap);    // mode in PAUSE: ignored
    press(4'b0010, 0, Hold, 12);     // resume
    press(4'b0001, 0, Hold, Gap);    // clear during RUN
    press(4'b1000, 0, Hold, Gap);    // mode in IDLE -> down
    press(4'b0010, 0, Hold, 25);     // run down-counting
    press(4'b0011, 0, Hold, Gap);    // clear beats start_stop
    press(4'b1110, 0, Hold, 10);     // start_stop beats plus2 and mode
    press(4'b0001, 0, Hold, Gap);
    press(4'b1000, 0, Hold, Gap);    // back to up

    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 99);
      if (r < 12)      b = 4'b0001;
      else if (r < 45) b = 4'b0010;
      else if (r < 60) b = 4'b0100;
      else if (r < 80) b = 4'b1000;
      else             b = 4'($urandom_range(1, 15));
      press(b, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
            Hold + $urandom_range(0, 3), int'(DB) + 3 + $urandom_range(0, 12));
    end

    press(4'b0001, 0, Hold, Gap);
    press(4'b0010, 0, Hold, Gap);    // in RUN when the asynchronous reset hits
    repeat (3) step();
    reset = 1'b0;
    phase = 1;
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Front-end control stage of the stopwatch, directly upstream of the seconds/minutes digit blocks. It debounces the four user buttons, runs the IDLE/RUN/PAUSE state machine and divides the system clock into the 1 Hz count tick. It drives the `start`, `ups`, `plus_min2` and `force_reset` inputs shared by every digit block.

## Interface
- `TICK_DIV`, 50_000_000: clock cycles per count tick; must be at least 2.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable synchronized samples needed to accept a button level change; must be at least 1.
- `clk` input 1: system clock; all state changes on the rising edge.
- `reset` input 1: one clock; reset is asynchronous and active-low.
- `btn_start_stop` input 1: raw asynchronous button; press toggles run/pause.
- `btn_mode` input 1: raw button; press toggles count direction.
- `btn_plus2` input 1: raw button; press adds 2 minutes.
- `btn_clear` input 1: raw button; press clears the count.
- `count_zero` input 1: high when all digits read 00:00, supplied by the digit chain.
- `start` output 1: one-cycle count tick to the digit chain.
- `ups` output 1: 1 = count up, 0 = count down; level signal.
- `plus_min2` output 1: one-cycle add-2-minutes pulse.
- `force_reset` output 1: one-cycle synchronous clear pulse to all digit registers.
- `running` output 1: high while in RUN.
- `done` output 1: one-cycle pulse when a down-count reaches zero.

## Operation
- **Button path (identical per button)**
  - 2-FF synchronizer feeds a debounce counter of width $clog2(DEBOUNCE_CYCLES+1).
  - The counter resets whenever the synchronized sample equals the debounced level.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the sample value and the counter clears.
  - A press event is a one-cycle pulse on the debounced 0->1 edge. Release produces no event.
- **Command priority** when several press events arrive in the same cycle: clear > start_stop > plus2 > mode. Only the highest-priority command acts; the lower ones are discarded.
- **States:** IDLE (count cleared), RUN, PAUSE. Encoding is free.
  - Any state + clear: go to IDLE, pulse `force_reset`, clear the prescaler.
  - IDLE + start_stop: go to RUN; the prescaler starts from 0.
  - RUN + start_stop: go to PAUSE; the prescaler value is held.
  - PAUSE + start_stop: go to RUN; the prescaler resumes from the held value.
  - RUN with `ups`=0 and `count_zero`=1, sampled at a tick: suppress that tick, pulse `done`, go to PAUSE.
  - IDLE/PAUSE + plus2: pulse `plus_min2` for one cycle. plus2 is ignored in RUN.
  - IDLE only + mode: toggle `ups`. mode is ignored in RUN and PAUSE.
- **Prescaler**
  - Width $clog2(TICK_DIV); counts 0..TICK_DIV-1 only in RUN and wraps to 0.
  - `start` = 1 for exactly the cycle the prescaler equals TICK_DIV-1 in RUN, unless suppressed by the zero rule above.
- **Reset values:** state IDLE, `ups`=1, `start`=0, `plus_min2`=0, `force_reset`=0, `running`=0, `done`=0. Prescaler, debounce counters and debounced levels are all 0.
- **Reset mid-operation:** asynchronous entry to the reset values. No `force_reset` pulse is generated; the digit blocks receive the system reset themselves.
- `start` and `plus_min2` are never high in the same cycle.

## Timing
- All outputs are registered.
- **Button latency:** the raw edge is synchronized in 2 cycles, debounced in DEBOUNCE_CYCLES cycles, and the press event adds 1 cycle. The command output follows in the next cycle, for a total of DEBOUNCE_CYCLES+4 cycles.
- **Tick spacing in continuous RUN:** exactly TICK_DIV cycles. The first tick after IDLE->RUN arrives TICK_DIV cycles after `running` rises.
- **Pause/resume:** the cycles spent in RUN before and after a pause add up, so no tick is lost or duplicated.
- `running` changes in the same cycle as the state register.
- `force_reset` goes high in the cycle the state enters IDLE.

## Test plan
- **Reset and idle:** with TICK_DIV=4, DEBOUNCE_CYCLES=3, hold `reset`=0 and then release -> all outputs at their reset values, `ups`=1. With no buttons pressed, `start` stays 0 for 100 cycles.
- **Debounce:** toggle `btn_start_stop` every 2 cycles for 20 cycles, then hold it high -> exactly one transition to RUN, occurring 7 cycles after the final stable edge.
- **Tick and pause:** press start_stop, run 10 cycles, pause for 20 cycles, resume -> `start` pulses at RUN-cycles 4 and 8, then at 12 counted in RUN time only; `start`=0 throughout PAUSE.
- **Clear during RUN:** press clear -> `force_reset` high for 1 cycle, `running`=0, state IDLE, prescaler 0. The next start_stop produces its first tick after 4 RUN cycles.
- **Mode and plus2 gating:**
  - Press mode in IDLE -> `ups`=0.
  - Press mode in RUN -> no change.
  - Press plus2 in PAUSE -> one `plus_min2` pulse.
  - Press plus2 in RUN -> none.
- **Down-count terminal:** in down mode, RUN with `count_zero`=1 at a tick cycle -> `start` stays 0, `done` pulses once, state PAUSE. Simultaneous clear and start_stop presses -> clear wins (IDLE, `force_reset` pulse).
